// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides
module seq_divider #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             q_ovf
);

  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DVD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [DVD_W-1:0] r_q;
  logic [DVS_W-1:0] r_d;
  // Partial remainder is always < D after an iteration, so DVS_W bits hold it;
  // the extra bit only lives in the trial value w_t.
  logic [DVS_W-1:0] r_r;

  logic [DVD_W-1:0] r_quot;
  logic [DVS_W-1:0] r_rem;
  logic             r_dbz;
  logic             r_ovf;

  logic [DVS_W:0]   w_t;
  logic             w_ge;
  logic [DVS_W-1:0] w_diff;
  logic [DVS_W-1:0] w_r_nxt;
  logic [DVD_W-1:0] w_q_nxt;
  logic [DVD_W-1:0] w_q_hi;
  logic             w_last;

  assign w_t     = {r_r, r_q[DVD_W-1]};
  assign w_ge    = (w_t >= {1'b0, r_d});
  assign w_diff  = DVS_W'(w_t - {1'b0, r_d});
  assign w_r_nxt = w_ge ? w_diff : w_t[DVS_W-1:0];
  assign w_q_nxt = {r_q[DVD_W-2:0], w_ge};
  assign w_q_hi  = w_q_nxt >> DVS_W;
  assign w_last  = (r_cnt == LAST_ITER);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = (divisor == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_r    <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= '0;
            if (divisor == '0) begin
              r_quot <= '1;
              r_rem  <= dividend[DVS_W-1:0];
              r_dbz  <= 1'b1;
              r_ovf  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_q   <= w_q_nxt;
          r_r   <= w_r_nxt;
          r_cnt <= r_cnt + 1'b1;
          // Result registers are separate so they survive the return to IDLE.
          if (w_last) begin
            r_quot <= w_q_nxt;
            r_rem  <= w_r_nxt;
            r_dbz  <= 1'b0;
            r_ovf  <= |w_q_hi;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign q_ovf       = r_ovf;

endmodule
